rom_loader: RTL and testbench
=============================

# rom_loader

Boot-time writer for the instruction ROM's write port. Accepts a byte stream (valid/ready) from a host link (UART receiver, debug bridge), packs bytes little-endian into 32-bit words, and issues one byte-masked write per word at consecutive word addresses starting from a programmable base. Optional read-back verification compares each written word against the ROM's combinational read port.

## Interface
- ADDR_W, 32: width of `MemAddrBus` addresses.
- CNT_W, 16: width of the written-word counter.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin a load session; sampled only in IDLE.
- base_addr_i  in  ADDR_W  byte address of the first word; bits [1:0] ignored (forced 0).
- byte_valid_i  in  1  stream byte valid.
- byte_data_i  in  8  stream byte.
- byte_last_i  in  1  qualifies the final byte of the session.
- byte_ready_o  out  1  stream ready.
- w_en_o  out  1  ROM write enable.
- w_addr_o  out  ADDR_W  ROM write byte address (word aligned).
- w_data_o  out  32  ROM write data.
- w_sel_o  out  4  ROM byte-lane write mask.
- r_addr_o  out  ADDR_W  ROM read address (verify only).
- r_data_i  in  32  ROM combinational read data (verify only).
- busy_o  out  1  session in progress.
- done_o  out  1  one-cycle pulse at session end.
- err_o  out  1  sticky verify mismatch.
- word_cnt_o  out  CNT_W  words written this session.

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, DONE; all outputs derive from registers.
- IDLE: byte_ready_o=0. start_i=1 -> LOAD; addr<=base_addr_i & ~3, lane<=0, acc<=0, sel<=0, word_cnt<=0, err<=0, last<=0.
- LOAD: byte_ready_o=1. On valid&&ready: acc[lane*8+:8]<=byte_data_i, sel[lane]<=1, lane<=lane+1, last<=byte_last_i. If lane==3 or byte_last_i -> WRITE.
- WRITE: byte_ready_o=0; w_en_o=1 exactly one cycle, w_addr_o=addr, w_data_o=acc (unfilled lanes 0), w_sel_o=sel. word_cnt<=word_cnt+1 (wraps mod 2^CNT_W). Next: VERIFY if enabled, else EXIT.
- VERIFY: r_addr_o=addr; for each lane with sel set, compare r_data_i lane to acc lane; any mismatch sets err (sticky until next start_i). Next: EXIT.
- EXIT rule: last=1 -> DONE; else addr<=addr+4 (wraps mod 2^ADDR_W), lane<=0, acc<=0, sel<=0 -> LOAD.
- DONE: done_o=1 one cycle -> IDLE.
- busy_o=1 in LOAD, WRITE, VERIFY, DONE.
- start_i outside IDLE ignored. byte_valid_i outside LOAD not accepted.
- Partial final word (1–3 bytes): written with w_sel_o containing only filled low lanes (4'b0001, 4'b0011, 4'b0111).
- Session ending exactly on a word boundary produces no extra empty write.

## Timing
- Reset values: state IDLE; byte_ready_o, w_en_o, busy_o, done_o, err_o = 0; w_addr_o, r_addr_o, w_data_o, w_sel_o, word_cnt_o = 0.
- Reset mid-session: immediate return to IDLE; partial word discarded; no write issued.
- Byte accepted on rising clk when byte_valid_i && byte_ready_o.
- Full word: 4 accept cycles + 1 WRITE (+1 VERIFY); sustained rate 4 bytes / 5 cycles (6 with verify).
- w_en_o asserts the cycle after the 4th (or last) byte accept; ROM captures on that cycle's rising edge.
- VERIFY samples r_data_i one cycle after the write edge.
- done_o asserts one cycle after the final WRITE (or VERIFY); busy_o deasserts the cycle after done_o.

## Configuration
- ROM_LOADER_VERIFY_EN defined: VERIFY state present; r_addr_o driven as above; err_o functional.
- Undefined: WRITE goes directly to EXIT; r_addr_o tied 0; r_data_i unused; err_o tied 0.

## Test plan
- Reset, start_i with base 0x0000_0103, stream 8 bytes 01..08 (last on 08) -> writes 0x0000_0100 data 0x04030201 sel 4'hF, then 0x0000_0104 data 0x08070605 sel 4'hF; word_cnt_o=2; done_o one pulse.
- Stream 5 bytes AA,BB,CC,DD,EE (last on EE) from base 0 -> second write addr 4, data 0x000000EE, sel 4'b0001; no third write.
- Valid gaps: byte_valid_i toggled every other cycle -> identical writes; w_en_o never asserted while lanes incomplete.
- Assert rst_n low after 2 bytes -> no write, all outputs 0, next start_i begins fresh at new base.
- With ROM_LOADER_VERIFY_EN: model ROM corrupts lane 2 of second word -> err_o rises in second VERIFY cycle, stays 1 through done_o, clears on next start_i.
- Base 0xFFFF_FFFC, 8 bytes -> second write address wraps to 0x0000_0000.

Source files
------------

// File: rtl/rom_loader_if.sv
// Byte-stream and ROM write/read-port bundle for rom_loader.
// The master modport is the loader side; slave is the host/ROM environment.
interface rom_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_last_i;
  logic              byte_ready_o;
  logic              w_en_o;
  logic [ADDR_W-1:0] w_addr_o;
  logic [31:0]       w_data_o;
  logic [3:0]        w_sel_o;
  logic [ADDR_W-1:0] r_addr_o;
  logic [31:0]       r_data_i;

  modport master (
    input  byte_valid_i, byte_data_i, byte_last_i, r_data_i,
    output byte_ready_o, w_en_o, w_addr_o, w_data_o, w_sel_o, r_addr_o
  );

  modport slave (
    output byte_valid_i, byte_data_i, byte_last_i, r_data_i,
    input  byte_ready_o, w_en_o, w_addr_o, w_data_o, w_sel_o, r_addr_o
  );
endinterface

// File: rtl/rom_loader.sv
// Boot-time ROM writer: packs a little-endian byte stream into byte-masked word writes.
// Define ROM_LOADER_VERIFY_EN to add a read-back compare state with a sticky error flag.
module rom_loader #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  rom_loader_if.master      bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  word_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
`ifdef ROM_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [31:0]       acc_q;
  logic [3:0]        sel_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wsel_q;
  logic              busy_q;
  logic              done_q;

  logic [31:0] acc_d;
  logic [3:0]  sel_d;
  logic        accept;
  logic        exit_now;

  always_comb begin
    acc_d = acc_q;
    acc_d[{lane_q, 3'b000} +: 8] = bus.byte_data_i;
    sel_d = sel_q;
    sel_d[lane_q] = 1'b1;
  end

  assign accept = (state_q == S_LOAD) && ready_q && bus.byte_valid_i;

`ifdef ROM_LOADER_VERIFY_EN
  logic              err_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              mismatch;

  always_comb begin
    mismatch = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel_q[i] && (bus.r_data_i[i*8 +: 8] != acc_q[i*8 +: 8])) mismatch = 1'b1;
    end
  end

  assign exit_now     = (state_q == S_VERIFY);
  assign err_o        = err_q;
  assign bus.r_addr_o = raddr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.r_data_i;
  assign exit_now     = (state_q == S_WRITE);
  assign err_o        = 1'b0;
  assign bus.r_addr_o = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      acc_q   <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wsel_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
      err_q   <= 1'b0;
      raddr_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_LOAD;
            addr_q  <= {base_addr_i[ADDR_W-1:2], 2'b00};
            lane_q  <= '0;
            acc_q   <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
`ifdef ROM_LOADER_VERIFY_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
            acc_q  <= acc_d;
            sel_q  <= sel_d;
            lane_q <= lane_q + 2'd1;
            last_q <= bus.byte_last_i;
            // Write registers load from the next-value terms so the word includes this byte.
            if (lane_q == 2'd3 || bus.byte_last_i) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              wen_q   <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= acc_d;
              wsel_q  <= sel_d;
            end
          end
        end
        S_WRITE: begin
          wen_q <= 1'b0;
          cnt_q <= cnt_q + CNT_W'(1);
`ifdef ROM_LOADER_VERIFY_EN
          state_q <= S_VERIFY;
          raddr_q <= addr_q;
`endif
        end
`ifdef ROM_LOADER_VERIFY_EN
        S_VERIFY: begin
          if (mismatch) err_q <= 1'b1;
        end
`endif
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Shared exit from the last write-phase state (WRITE or VERIFY) overrides its next state.
      if (exit_now) begin
        if (last_q) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= S_LOAD;
          addr_q  <= addr_q + ADDR_W'(4);
          lane_q  <= '0;
          acc_q   <= '0;
          sel_q   <= '0;
          ready_q <= 1'b1;
        end
      end
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign bus.w_en_o       = wen_q;
  assign bus.w_addr_o     = waddr_q;
  assign bus.w_data_o     = wdata_q;
  assign bus.w_sel_o      = wsel_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign word_cnt_o       = cnt_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected ROM writes are queued per session and
// popped as w_en_o pulses; a small ROM model backs the optional read-back path.
module tb_rom_loader;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [CNT_W-1:0]  word_cnt_o;

  rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rom_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim_bytes[$];
  int         checks = 0;
  int         failures = 0;
  int         done_cycles = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ROM model: byte-masked capture; optional corruption of lane 2 at one address.
  logic [31:0] rom [0:255];
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (bus.w_en_o) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.w_sel_o[l])
          rom[bus.w_addr_o[9:2]][l*8 +: 8] <= bus.w_data_o[l*8 +: 8] ^
            ((corrupt_en && bus.w_addr_o == corrupt_addr && l == 2) ? 8'hFF : 8'h00);
      end
    end
  end

  assign bus.r_data_i = rom[bus.r_addr_o[9:2]];

  // Write monitor / scoreboard pop.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.w_en_o) begin
      chk("ready_low_in_write", {63'd0, bus.byte_ready_o}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'd0, bus.w_en_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("w_addr", {32'd0, bus.w_addr_o}, {32'd0, e.addr});
        chk("w_data", {32'd0, bus.w_data_o}, {32'd0, e.data});
        chk("w_sel", {60'd0, bus.w_sel_o}, {60'd0, e.sel});
      end
    end
    if (done_o) done_cycles++;
  end

  task automatic reset_check(input string name);
    chk({name, "_ready"}, {63'd0, bus.byte_ready_o}, 64'd0);
    chk({name, "_wen"},   {63'd0, bus.w_en_o}, 64'd0);
    chk({name, "_busy"},  {63'd0, busy_o}, 64'd0);
    chk({name, "_done"},  {63'd0, done_o}, 64'd0);
    chk({name, "_err"},   {63'd0, err_o}, 64'd0);
    chk({name, "_waddr"}, {32'd0, bus.w_addr_o}, 64'd0);
    chk({name, "_raddr"}, {32'd0, bus.r_addr_o}, 64'd0);
    chk({name, "_wdata"}, {32'd0, bus.w_data_o}, 64'd0);
    chk({name, "_wsel"},  {60'd0, bus.w_sel_o}, 64'd0);
    chk({name, "_cnt"},   {48'd0, word_cnt_o}, 64'd0);
  endtask

  // Drives one session from stim_bytes. abort_n>0 stops after that many bytes (no writes expected).
  task automatic run_session(input logic [31:0] base, input bit gap, input int abort_n,
                             input bit exp_err, input string name);
    int          n = stim_bytes.size();
    int          budget;
    logic [31:0] a = base & ~32'h3;
    wr_t         e;
    if (abort_n == 0) begin
      for (int w = 0; w < (n + 3) / 4; w++) begin
        e.addr = a + 32'(w * 4);
        e.data = '0;
        e.sel  = '0;
        for (int l = 0; l < 4; l++) begin
          if (w * 4 + l < n) begin
            e.data[l*8 +: 8] = stim_bytes[w*4 + l];
            e.sel[l] = 1'b1;
          end
        end
        exp_q.push_back(e);
      end
    end
    done_cycles = 0;
    base_addr_i = base;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({name, "_err_clear_on_start"}, {63'd0, err_o}, 64'd0);
    chk({name, "_busy_on_start"}, {63'd0, busy_o}, 64'd1);
    for (int i = 0; i < n; i++) begin
      if (abort_n != 0 && i == abort_n) break;
      if (gap) begin
        bus.byte_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = stim_bytes[i];
      bus.byte_last_i  = (i == n - 1);
      budget = 0;
      while (!bus.byte_ready_o && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!bus.byte_ready_o) chk({name, "_ready_timeout"}, {63'd0, bus.byte_ready_o}, 64'd1);
      @(posedge clk); #1;
    end
    bus.byte_valid_i = 1'b0;
    bus.byte_last_i  = 1'b0;
    if (abort_n != 0) return;
    budget = 0;
    while (!done_o && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk({name, "_done_seen"}, {63'd0, done_o}, 64'd1);
    chk({name, "_word_cnt"}, {48'd0, word_cnt_o}, 64'((n + 3) / 4));
    chk({name, "_err_at_done"}, {63'd0, err_o}, {63'd0, exp_err});
`ifndef ROM_LOADER_VERIFY_EN
    chk({name, "_raddr_tied"}, {32'd0, bus.r_addr_o}, 64'd0);
`endif
    @(posedge clk); #1;
    chk({name, "_busy_after_done"}, {63'd0, busy_o}, 64'd0);
    chk({name, "_done_one_cycle"}, 64'(done_cycles), 64'd1);
    chk({name, "_no_extra_write"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = '0;
    bus.byte_last_i  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_check("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    stim_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_session(32'h0000_0103, 1'b0, 0, 1'b0, "full2");

    stim_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_session(32'h0000_0000, 1'b0, 0, 1'b0, "partial1");

    stim_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_session(32'h0000_0103, 1'b1, 0, 1'b0, "gaps");

    stim_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_session(32'h0000_0040, 1'b0, 2, 1'b0, "abort");
    rst_n = 1'b0;
    #1;
    reset_check("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_write_queued", 64'(exp_q.size()), 64'd0);

    stim_bytes = '{8'h91, 8'h92, 8'h93};
    run_session(32'h0000_0202, 1'b0, 0, 1'b0, "fresh3");

    stim_bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    run_session(32'hFFFF_FFFC, 1'b0, 0, 1'b0, "wrap");

`ifdef ROM_LOADER_VERIFY_EN
    corrupt_addr = 32'h0000_0004;
    corrupt_en   = 1'b1;
    stim_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_session(32'h0000_0000, 1'b0, 0, 1'b1, "verify_bad");
    chk("err_sticky_after_done", {63'd0, err_o}, 64'd1);
    corrupt_en = 1'b0;
    stim_bytes = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    run_session(32'h0000_0300, 1'b0, 0, 1'b0, "verify_good");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
